// File: rtl/n2_irf_wswap_pkg.sv
// Shared definitions for the IRF window/global save-restore sequencer:
// op encodings, FSM states and default geometry.
package n2_irf_wswap_pkg;

   localparam int unsigned NUM_LOCAL_DFLT = 8;
   localparam int unsigned NUM_EO_DFLT    = 4;

   localparam logic [1:0] WOP_NULL    = 2'b00;
   localparam logic [1:0] WOP_SAVE    = 2'b01;
   localparam logic [1:0] WOP_RESTORE = 2'b10;
   localparam logic [1:0] WOP_SWAP    = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StSave,
      StGap,
      StRestore,
      StGlb,
      StWnull,
      StDone
   } wswap_state_e;

   // States that touch the array and therefore yield to pipeline writes.
   function automatic logic st_holdable(input wswap_state_e st);
      return (st == StSave) || (st == StRestore) || (st == StGlb);
   endfunction

endpackage

// File: rtl/n2_irf_wswap_rr_arb.sv
// Two-way round-robin arbiter between window and global swap requests.
// Grants only while the sequencer is idle; pointer remembers the last winner.
module n2_irf_wswap_rr_arb (
   input  logic l2clk,
   input  logic rst_l,
   input  logic idle,
   input  logic win_vld,
   input  logic glb_vld,
   output logic win_gnt,
   output logic glb_gnt
);

   logic ptr_glb_q;  // 1: last grant went to the global side

   always_comb begin
      win_gnt = idle & win_vld & (~glb_vld | ptr_glb_q);
      glb_gnt = idle & glb_vld & (~win_vld | ~ptr_glb_q);
   end

   always_ff @(posedge l2clk or negedge rst_l) begin
      if (!rst_l) begin
         ptr_glb_q <= 1'b0;
      end else if (win_gnt) begin
         ptr_glb_q <= 1'b0;
      end else if (glb_gnt) begin
         ptr_glb_q <= 1'b1;
      end
   end

endmodule

// File: rtl/n2_irf_wswap_ctl.sv
// IRF window/global save-restore sequencer: steps the array swap ports one row
// per cycle, yielding to wr_hold. Optional counters under IRF_WSWAP_PERF_EN.
module n2_irf_wswap_ctl
   import n2_irf_wswap_pkg::*;
#(
   parameter int unsigned NUM_LOCAL = NUM_LOCAL_DFLT,
   parameter int unsigned NUM_EO    = NUM_EO_DFLT
) (
   input  logic       l2clk,
   input  logic       rst_l,
   input  logic       win_req_vld,
   output logic       win_req_rdy,
   input  logic [1:0] win_req_tid,
   input  logic [1:0] win_req_op,
   input  logic [2:0] win_req_old_cwp,
   input  logic [2:0] win_req_new_cwp,
   input  logic       glb_req_vld,
   output logic       glb_req_rdy,
   input  logic [1:0] glb_req_tid,
   input  logic       glb_req_restore,
   input  logic [1:0] glb_req_set,
   input  logic       wr_hold,
   output logic [1:0] save_tid,
   output logic [1:0] restore_tid,
   output logic [2:0] save_local_addr,
   output logic [2:0] restore_local_addr,
   output logic [1:0] save_even_addr,
   output logic [1:0] save_odd_addr,
   output logic [1:0] restore_even_addr,
   output logic [1:0] restore_odd_addr,
   output logic       save_local_en,
   output logic       save_even_en,
   output logic       save_odd_en,
   output logic       restore_local_en,
   output logic       restore_even_en,
   output logic       restore_odd_en,
   output logic       save_global_en,
   output logic       restore_global_en,
   output logic [1:0] save_global_tid,
   output logic [1:0] restore_global_tid,
   output logic [1:0] save_global_addr,
   output logic [1:0] restore_global_addr,
   output logic       win_done,
   output logic       glb_done,
`ifdef IRF_WSWAP_PERF_EN
   output logic [15:0] stall_cnt,
   output logic [15:0] swap_cnt,
`endif
   output logic       busy
);

   localparam int unsigned STEP_W = $clog2(NUM_LOCAL);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_LOCAL - 1);

   wswap_state_e      state_q;
   logic [STEP_W-1:0] step_q;
   logic [1:0]        tid_q;
   logic [1:0]        op_q;
   logic              old_odd_q;
   logic              new_odd_q;
   logic              glb_rst_q;
   logic [1:0]        glb_set_q;
   logic              is_glb_q;

   logic win_acc, glb_acc;
   logic eo_step, bank_odd;
   logic [1:0] bank_addr;
   logic unused_cwp_hi;

   // Only the window parity selects the even/odd bank.
   assign unused_cwp_hi = ^{win_req_old_cwp[2:1], win_req_new_cwp[2:1]};

   n2_irf_wswap_rr_arb u_arb (
      .l2clk   (l2clk),
      .rst_l   (rst_l),
      .idle    (state_q == StIdle),
      .win_vld (win_req_vld),
      .glb_vld (glb_req_vld),
      .win_gnt (win_req_rdy),
      .glb_gnt (glb_req_rdy)
   );

   assign win_acc   = win_req_vld & win_req_rdy;
   assign glb_acc   = glb_req_vld & glb_req_rdy;
   assign busy      = (state_q != StIdle);
   assign eo_step   = 32'(step_q) < NUM_EO;
   assign bank_odd  = (state_q == StRestore) ? new_odd_q : old_odd_q;
   assign bank_addr = 2'(step_q);

   always_ff @(posedge l2clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q             <= StIdle;
         step_q              <= '0;
         tid_q               <= '0;
         op_q                <= WOP_NULL;
         old_odd_q           <= 1'b0;
         new_odd_q           <= 1'b0;
         glb_rst_q           <= 1'b0;
         glb_set_q           <= '0;
         is_glb_q            <= 1'b0;
         save_tid            <= '0;
         restore_tid         <= '0;
         save_local_addr     <= '0;
         restore_local_addr  <= '0;
         save_even_addr      <= '0;
         save_odd_addr       <= '0;
         restore_even_addr   <= '0;
         restore_odd_addr    <= '0;
         save_local_en       <= 1'b0;
         save_even_en        <= 1'b0;
         save_odd_en         <= 1'b0;
         restore_local_en    <= 1'b0;
         restore_even_en     <= 1'b0;
         restore_odd_en      <= 1'b0;
         save_global_en      <= 1'b0;
         restore_global_en   <= 1'b0;
         save_global_tid     <= '0;
         restore_global_tid  <= '0;
         save_global_addr    <= '0;
         restore_global_addr <= '0;
         win_done            <= 1'b0;
         glb_done            <= 1'b0;
      end else begin
         // Array-facing outputs are pulses: cleared unless driven this cycle.
         save_tid            <= '0;
         restore_tid         <= '0;
         save_local_addr     <= '0;
         restore_local_addr  <= '0;
         save_even_addr      <= '0;
         save_odd_addr       <= '0;
         restore_even_addr   <= '0;
         restore_odd_addr    <= '0;
         save_local_en       <= 1'b0;
         save_even_en        <= 1'b0;
         save_odd_en         <= 1'b0;
         restore_local_en    <= 1'b0;
         restore_even_en     <= 1'b0;
         restore_odd_en      <= 1'b0;
         save_global_en      <= 1'b0;
         restore_global_en   <= 1'b0;
         save_global_tid     <= '0;
         restore_global_tid  <= '0;
         save_global_addr    <= '0;
         restore_global_addr <= '0;
         win_done            <= 1'b0;
         glb_done            <= 1'b0;

         case (state_q)
            StIdle: begin
               if (win_acc) begin
                  tid_q     <= win_req_tid;
                  op_q      <= win_req_op;
                  old_odd_q <= win_req_old_cwp[0];
                  new_odd_q <= win_req_new_cwp[0];
                  is_glb_q  <= 1'b0;
                  step_q    <= '0;
                  case (win_req_op)
                     WOP_SAVE, WOP_SWAP: state_q <= StSave;
                     WOP_RESTORE:        state_q <= StRestore;
                     default:            state_q <= StWnull;
                  endcase
               end else if (glb_acc) begin
                  tid_q     <= glb_req_tid;
                  glb_rst_q <= glb_req_restore;
                  glb_set_q <= glb_req_set;
                  is_glb_q  <= 1'b1;
                  state_q   <= StGlb;
               end
            end
            StSave: begin
               if (!wr_hold) begin
                  save_local_en   <= 1'b1;
                  save_local_addr <= 3'(step_q);
                  save_tid        <= tid_q;
                  if (eo_step) begin
                     save_even_en   <= ~bank_odd;
                     save_odd_en    <= bank_odd;
                     save_even_addr <= bank_odd ? 2'b00 : bank_addr;
                     save_odd_addr  <= bank_odd ? bank_addr : 2'b00;
                  end
                  if (step_q == LAST_STEP) begin
                     step_q  <= '0;
                     state_q <= (op_q == WOP_SWAP) ? StGap : StDone;
                  end else begin
                     step_q <= step_q + 1'b1;
                  end
               end
            end
            StGap: state_q <= StRestore;
            StRestore: begin
               if (!wr_hold) begin
                  restore_local_en   <= 1'b1;
                  restore_local_addr <= 3'(step_q);
                  restore_tid        <= tid_q;
                  if (eo_step) begin
                     restore_even_en   <= ~bank_odd;
                     restore_odd_en    <= bank_odd;
                     restore_even_addr <= bank_odd ? 2'b00 : bank_addr;
                     restore_odd_addr  <= bank_odd ? bank_addr : 2'b00;
                  end
                  if (step_q == LAST_STEP) begin
                     step_q  <= '0;
                     state_q <= StDone;
                  end else begin
                     step_q <= step_q + 1'b1;
                  end
               end
            end
            StGlb: begin
               if (!wr_hold) begin
                  if (glb_rst_q) begin
                     restore_global_en   <= 1'b1;
                     restore_global_addr <= glb_set_q;
                     restore_global_tid  <= tid_q;
                  end else begin
                     save_global_en   <= 1'b1;
                     save_global_addr <= glb_set_q;
                     save_global_tid  <= tid_q;
                  end
                  state_q <= StDone;
               end
            end
            StWnull: state_q <= StDone;
            StDone: begin
               win_done <= ~is_glb_q;
               glb_done <= is_glb_q;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef IRF_WSWAP_PERF_EN
   always_ff @(posedge l2clk or negedge rst_l) begin
      if (!rst_l) begin
         stall_cnt <= '0;
         swap_cnt  <= '0;
      end else begin
         if (wr_hold && st_holdable(state_q) && (stall_cnt != 16'hffff)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
         if ((state_q == StDone) && !is_glb_q) begin
            swap_cnt <= swap_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_n2_irf_wswap_ctl.sv
// Self-checking bench for n2_irf_wswap_ctl: every cycle after accept is compared
// against a slot schedule derived from the request, hold pattern and rr pointer.
module tb_n2_irf_wswap_ctl;

   localparam int NUM_LOCAL = 8;
   localparam int NUM_EO    = 4;

   typedef struct packed {
      logic [1:0] save_tid, restore_tid;
      logic [2:0] save_local_addr, restore_local_addr;
      logic [1:0] save_even_addr, save_odd_addr, restore_even_addr, restore_odd_addr;
      logic save_local_en, save_even_en, save_odd_en;
      logic restore_local_en, restore_even_en, restore_odd_en;
      logic save_global_en, restore_global_en;
      logic [1:0] save_global_tid, restore_global_tid, save_global_addr, restore_global_addr;
      logic win_done, glb_done, busy, win_rdy, glb_rdy;
   } obs_t;

   typedef struct packed {
      logic       is_glb;
      logic [1:0] op;
      logic [1:0] tid;
      logic [2:0] ocwp, ncwp;
      logic       rst;
      logic [1:0] set;
   } req_t;

   // kind: 0 save step, 1 restore step, 2 gap, 3 global, 4 null
   typedef struct packed {
      logic [2:0] kind;
      logic [2:0] k;
   } slot_t;

   logic l2clk = 1'b0;
   logic rst_l = 1'b0;
   logic win_req_vld = 1'b0, glb_req_vld = 1'b0, wr_hold = 1'b0;
   logic win_req_rdy, glb_req_rdy;
   logic [1:0] win_req_tid = '0, win_req_op = '0, glb_req_tid = '0, glb_req_set = '0;
   logic [2:0] win_req_old_cwp = '0, win_req_new_cwp = '0;
   logic glb_req_restore = 1'b0;
   logic [1:0] save_tid, restore_tid;
   logic [2:0] save_local_addr, restore_local_addr;
   logic [1:0] save_even_addr, save_odd_addr, restore_even_addr, restore_odd_addr;
   logic save_local_en, save_even_en, save_odd_en;
   logic restore_local_en, restore_even_en, restore_odd_en;
   logic save_global_en, restore_global_en;
   logic [1:0] save_global_tid, restore_global_tid, save_global_addr, restore_global_addr;
   logic win_done, glb_done, busy;

   int n_chk  = 0;
   int n_pass = 0;
   logic ptr_glb = 1'b0;  // model of round-robin pointer (1 = last grant global)

   always #5 l2clk = ~l2clk;

   n2_irf_wswap_ctl dut (
      .l2clk(l2clk), .rst_l(rst_l),
      .win_req_vld(win_req_vld), .win_req_rdy(win_req_rdy), .win_req_tid(win_req_tid),
      .win_req_op(win_req_op), .win_req_old_cwp(win_req_old_cwp),
      .win_req_new_cwp(win_req_new_cwp),
      .glb_req_vld(glb_req_vld), .glb_req_rdy(glb_req_rdy), .glb_req_tid(glb_req_tid),
      .glb_req_restore(glb_req_restore), .glb_req_set(glb_req_set),
      .wr_hold(wr_hold),
      .save_tid(save_tid), .restore_tid(restore_tid),
      .save_local_addr(save_local_addr), .restore_local_addr(restore_local_addr),
      .save_even_addr(save_even_addr), .save_odd_addr(save_odd_addr),
      .restore_even_addr(restore_even_addr), .restore_odd_addr(restore_odd_addr),
      .save_local_en(save_local_en), .save_even_en(save_even_en), .save_odd_en(save_odd_en),
      .restore_local_en(restore_local_en), .restore_even_en(restore_even_en),
      .restore_odd_en(restore_odd_en),
      .save_global_en(save_global_en), .restore_global_en(restore_global_en),
      .save_global_tid(save_global_tid), .restore_global_tid(restore_global_tid),
      .save_global_addr(save_global_addr), .restore_global_addr(restore_global_addr),
      .win_done(win_done), .glb_done(glb_done), .busy(busy)
   );

   function automatic obs_t sample();
      obs_t o;
      o.save_tid = save_tid;                 o.restore_tid = restore_tid;
      o.save_local_addr = save_local_addr;   o.restore_local_addr = restore_local_addr;
      o.save_even_addr = save_even_addr;     o.save_odd_addr = save_odd_addr;
      o.restore_even_addr = restore_even_addr; o.restore_odd_addr = restore_odd_addr;
      o.save_local_en = save_local_en;       o.save_even_en = save_even_en;
      o.save_odd_en = save_odd_en;           o.restore_local_en = restore_local_en;
      o.restore_even_en = restore_even_en;   o.restore_odd_en = restore_odd_en;
      o.save_global_en = save_global_en;     o.restore_global_en = restore_global_en;
      o.save_global_tid = save_global_tid;   o.restore_global_tid = restore_global_tid;
      o.save_global_addr = save_global_addr; o.restore_global_addr = restore_global_addr;
      o.win_done = win_done; o.glb_done = glb_done; o.busy = busy;
      o.win_rdy = win_req_rdy; o.glb_rdy = glb_req_rdy;
      return o;
   endfunction

   function automatic obs_t base_mask();
      obs_t m = '0;
      m.save_local_en = 1'b1; m.save_even_en = 1'b1; m.save_odd_en = 1'b1;
      m.restore_local_en = 1'b1; m.restore_even_en = 1'b1; m.restore_odd_en = 1'b1;
      m.save_global_en = 1'b1; m.restore_global_en = 1'b1;
      m.win_done = 1'b1; m.glb_done = 1'b1; m.busy = 1'b1; m.win_rdy = 1'b1; m.glb_rdy = 1'b1;
      return m;
   endfunction

   function automatic req_t rand_req(input logic g);
      req_t r;
      r.is_glb = g;
      r.op     = 2'($urandom_range(3));
      r.tid    = 2'($urandom_range(3));
      r.ocwp   = 3'($urandom_range(7));
      r.ncwp   = 3'($urandom_range(7));
      r.rst    = 1'($urandom_range(1));
      r.set    = 2'($urandom_range(3));
      return r;
   endfunction

   task automatic put_win(input req_t r);
      win_req_vld = 1'b1; win_req_tid = r.tid; win_req_op = r.op;
      win_req_old_cwp = r.ocwp; win_req_new_cwp = r.ncwp;
   endtask

   task automatic put_glb(input req_t r);
      glb_req_vld = 1'b1; glb_req_tid = r.tid; glb_req_restore = r.rst; glb_req_set = r.set;
   endtask

   // Starts at the negedge after the accept edge; ends at the negedge after the done edge.
   task automatic follow(input string nm, input req_t r, input logic [63:0] hp);
      slot_t q[$];
      obs_t  o, e, m;
      int    si;
      logic  par;
      logic [1:0] kb;
      if (r.is_glb) q.push_back(slot_t'{3'd3, 3'd0});
      else if (r.op == 2'b00) q.push_back(slot_t'{3'd4, 3'd0});
      else begin
         if (r.op[0]) for (int k = 0; k < NUM_LOCAL; k++) q.push_back(slot_t'{3'd0, 3'(k)});
         if (r.op == 2'b11) q.push_back(slot_t'{3'd2, 3'd0});
         if (r.op[1]) for (int k = 0; k < NUM_LOCAL; k++) q.push_back(slot_t'{3'd1, 3'(k)});
      end
      si = 0;
      for (int t = 1; t <= 200 && si <= q.size(); t++) begin
         wr_hold = (t < 64) ? hp[t] : 1'b0;
         @(posedge l2clk);
         @(negedge l2clk);
         o = sample();
         e = '0;
         m = base_mask();
         if (si < q.size()) begin
            e.busy = 1'b1;
            if (!(wr_hold && (q[si].kind == 3'd0 || q[si].kind == 3'd1 || q[si].kind == 3'd3)))
            begin
               par = (q[si].kind == 3'd0) ? r.ocwp[0] : r.ncwp[0];
               kb  = q[si].k[1:0];
               if (q[si].kind == 3'd0) begin
                  e.save_local_en = 1'b1; e.save_local_addr = q[si].k; e.save_tid = r.tid;
                  m.save_local_addr = '1; m.save_tid = '1;
                  if (int'(q[si].k) < NUM_EO) begin
                     e.save_even_en = ~par; e.save_odd_en = par;
                     e.save_even_addr = par ? 2'b00 : kb; e.save_odd_addr = par ? kb : 2'b00;
                     m.save_even_addr = '1; m.save_odd_addr = '1;
                  end
               end else if (q[si].kind == 3'd1) begin
                  e.restore_local_en = 1'b1; e.restore_local_addr = q[si].k;
                  e.restore_tid = r.tid;
                  m.restore_local_addr = '1; m.restore_tid = '1;
                  if (int'(q[si].k) < NUM_EO) begin
                     e.restore_even_en = ~par; e.restore_odd_en = par;
                     e.restore_even_addr = par ? 2'b00 : kb;
                     e.restore_odd_addr = par ? kb : 2'b00;
                     m.restore_even_addr = '1; m.restore_odd_addr = '1;
                  end
               end else if (q[si].kind == 3'd3) begin
                  if (r.rst) begin
                     e.restore_global_en = 1'b1; e.restore_global_addr = r.set;
                     e.restore_global_tid = r.tid;
                     m.restore_global_addr = '1; m.restore_global_tid = '1;
                  end else begin
                     e.save_global_en = 1'b1; e.save_global_addr = r.set;
                     e.save_global_tid = r.tid;
                     m.save_global_addr = '1; m.save_global_tid = '1;
                  end
               end
               si++;
            end
         end else begin
            e.win_done = ~r.is_glb;
            e.glb_done = r.is_glb;
            e.win_rdy  = win_req_vld;
            e.glb_rdy  = glb_req_vld;
            si++;
         end
         n_chk++;
         if (((o ^ e) & m) !== '0)
            $display("FAIL %s cycle T+%0d: got %h required %h (mask %h)", nm, t, o, e, m);
         else n_pass++;
      end
      wr_hold = 1'b0;
   endtask

   task automatic do_single(input string nm, input req_t r, input logic [63:0] hp);
      @(negedge l2clk);
      if (r.is_glb) put_glb(r); else put_win(r);
      #1;
      n_chk++;
      if ({win_req_rdy, glb_req_rdy} !== {~r.is_glb, r.is_glb})
         $display("FAIL %s rdy: got %b required %b", nm, {win_req_rdy, glb_req_rdy},
                  {~r.is_glb, r.is_glb});
      else n_pass++;
      @(posedge l2clk);
      @(negedge l2clk);
      win_req_vld = 1'b0; glb_req_vld = 1'b0;
      ptr_glb = r.is_glb;
      follow(nm, r, hp);
   endtask

   task automatic do_both(input string nm, input req_t rw, input req_t rg,
                          input logic [63:0] hpw, input logic [63:0] hpg);
      logic [1:0] exp_g;
      @(negedge l2clk);
      put_win(rw); put_glb(rg);
      #1;
      exp_g = ptr_glb ? 2'b10 : 2'b01;
      n_chk++;
      if ({win_req_rdy, glb_req_rdy} !== exp_g)
         $display("FAIL %s arb: got %b required %b", nm, {win_req_rdy, glb_req_rdy}, exp_g);
      else n_pass++;
      @(posedge l2clk);
      @(negedge l2clk);
      if (!ptr_glb) begin
         glb_req_vld = 1'b0; ptr_glb = 1'b1;
         follow({nm, "_glb"}, rg, hpg);
         @(posedge l2clk);
         @(negedge l2clk);
         win_req_vld = 1'b0; ptr_glb = 1'b0;
         follow({nm, "_win"}, rw, hpw);
      end else begin
         win_req_vld = 1'b0; ptr_glb = 1'b0;
         follow({nm, "_win"}, rw, hpw);
         @(posedge l2clk);
         @(negedge l2clk);
         glb_req_vld = 1'b0; ptr_glb = 1'b1;
         follow({nm, "_glb"}, rg, hpg);
      end
   endtask

   task automatic test_reset();
      obs_t o;
      repeat (2) @(posedge l2clk);
      #1;
      o = sample();
      n_chk++;
      if (o !== '0) $display("FAIL reset_hold: got %h required 0", o);
      else n_pass++;
      @(negedge l2clk);
      rst_l = 1'b1;
      @(negedge l2clk);
      o = sample();
      n_chk++;
      if (o !== '0) $display("FAIL reset_release: got %h required 0", o);
      else n_pass++;
      ptr_glb = 1'b0;
   endtask

   task automatic test_save();
      do_single("save", req_t'{1'b0, 2'b01, 2'd2, 3'd3, 3'd0, 1'b0, 2'd0}, 64'd0);
   endtask

   task automatic test_swap();
      do_single("swap", req_t'{1'b0, 2'b11, 2'd1, 3'd2, 3'd5, 1'b0, 2'd0}, 64'd0);
   endtask

   task automatic test_restore_hold();
      logic [63:0] hp;
      hp = 64'd0;
      hp[3] = 1'b1; hp[4] = 1'b1; hp[5] = 1'b1;
      do_single("restore_hold", req_t'{1'b0, 2'b10, 2'd3, 3'd0, 3'd6, 1'b0, 2'd0}, hp);
   endtask

   task automatic test_null();
      do_single("null", req_t'{1'b0, 2'b00, 2'd0, 3'd1, 3'd2, 1'b0, 2'd0}, 64'd0);
   endtask

   task automatic test_arb();
      do_both("arb", req_t'{1'b0, 2'b01, 2'd3, 3'd1, 3'd0, 1'b0, 2'd0},
              req_t'{1'b1, 2'b00, 2'd1, 3'd0, 3'd0, 1'b0, 2'd2}, 64'd0, 64'd0);
   endtask

   task automatic test_reset_mid();
      obs_t o;
      logic seen;
      @(negedge l2clk);
      put_win(req_t'{1'b0, 2'b01, 2'd1, 3'd4, 3'd0, 1'b0, 2'd0});
      @(posedge l2clk);
      @(negedge l2clk);
      win_req_vld = 1'b0;
      repeat (5) begin
         @(posedge l2clk);
         @(negedge l2clk);
      end
      n_chk++;
      if (save_local_en !== 1'b1 || save_local_addr !== 3'd4)
         $display("FAIL reset_mid_step4: got en=%b addr=%0d required en=1 addr=4",
                  save_local_en, save_local_addr);
      else n_pass++;
      #2 rst_l = 1'b0;
      #1 o = sample();
      n_chk++;
      if (o !== '0) $display("FAIL reset_mid_clear: got %h required 0", o);
      else n_pass++;
      ptr_glb = 1'b0;
      @(negedge l2clk);
      rst_l = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(negedge l2clk);
         if (win_done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      n_chk++;
      if (seen !== 1'b0) $display("FAIL reset_mid_quiet: got activity=%b required 0", seen);
      else n_pass++;
      // pointer back at win after reset: global goes first
      do_both("post_reset", req_t'{1'b0, 2'b10, 2'd2, 3'd0, 3'd3, 1'b0, 2'd0},
              req_t'{1'b1, 2'b00, 2'd3, 3'd0, 3'd0, 1'b1, 2'd1}, 64'd0, 64'd0);
   endtask

   task automatic test_random();
      req_t rw, rg;
      logic [63:0] hw, hg;
      int mode;
      for (int i = 0; i < 16; i++) begin
         rw = rand_req(1'b0);
         rg = rand_req(1'b1);
         hw = {$urandom, $urandom} & {$urandom, $urandom};
         hg = {$urandom, $urandom} & {$urandom, $urandom};
         mode = $urandom_range(2);
         if (mode == 0) do_single("rand_win", rw, hw);
         else if (mode == 1) do_single("rand_glb", rg, hg);
         else do_both("rand_both", rw, rg, hw, hg);
      end
   endtask

   initial begin
      test_reset();
      test_save();
      test_swap();
      test_restore_hold();
      test_null();
      test_arb();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
